cache_ctrl: RTL and testbench

Cache controller that drives the request/ack port of the 16-set direct-mapped cache array from a single-issue CPU port, and services misses from a word-wide backing memory. It sits between the CPU and the cache array. It performs cache initialisation after reset, hit lookups, dirty-line write-back and line fill, and then completes the CPU access. It is the initiator for the cache's enable/ack handshake.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/req_hs.sv | 33 +++
 rtl/cache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address field helpers for the cache controller.
package cache_pkg;

  localparam int TAG_W  = 5;
  localparam int IDX_W  = 4;
  localparam int WORD_W = 2;
  localparam int DATA_W = 16;
  localparam int ADDR_W = TAG_W + IDX_W + WORD_W;

  typedef enum logic [2:0] {
    INIT, IDLE, LOOKUP, WB_RD, WB_MEM, FILL_MEM, FILL_WR, DONE
  } state_e;

  typedef enum logic {HS_READY, HS_WAIT_LOW} hs_phase_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[WORD_W +: IDX_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[WORD_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [WORD_W-1:0] w);
    return {t, i, w};
  endfunction

endpackage

// File: rtl/req_hs.sv
// Request/ack sequencer: req follows start until ack, then (4-phase mode) waits for ack low.
module req_hs import cache_pkg::*; #(
  parameter bit WAIT_ACK_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic done_pulse,
  output logic busy
);

  hs_phase_e phase;

  // Reset into WAIT_LOW so the first request also waits for a deasserted ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= HS_WAIT_LOW;
    end else begin
      case (phase)
        HS_READY:    if (WAIT_ACK_LOW && done_pulse) phase <= HS_WAIT_LOW;
        HS_WAIT_LOW: if (!ack) phase <= HS_READY;
        default:     phase <= HS_WAIT_LOW;
      endcase
    end
  end

  assign req        = start && (phase == HS_READY);
  assign done_pulse = req && ack;
  assign busy       = (phase != HS_READY) || req;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: init, hit lookup, dirty write-back, line fill, CPU completion.
module cache_ctrl import cache_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              c_enable,
  output logic              c_rst,
  output logic [IDX_W-1:0]  c_index,
  output logic [WORD_W-1:0] c_word,
  output logic [TAG_W-1:0]  c_tag_in,
  output logic [DATA_W-1:0] c_data_in,
  output logic              c_comp,
  output logic              c_write,
  output logic              c_valid_in,
  input  logic              c_hit,
  input  logic              c_dirty,
  input  logic              c_valid,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic [DATA_W-1:0] c_data_out,
  input  logic              c_ack,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_e state, state_d;
  logic [WORD_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_p0;
  logic              wr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [TAG_W-1:0]  victim_tag_p1;
  logic [DATA_W-1:0] word_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic c_start, c_done, c_busy;
  logic m_start, m_done, m_busy;

  // Gating start with rst drops c_enable/mem_req in the same cycle rst is seen.
  assign c_start = !rst && (state inside {INIT, LOOKUP, WB_RD, FILL_WR});
  assign m_start = !rst && (state inside {WB_MEM, FILL_MEM});

  req_hs #(.WAIT_ACK_LOW(1'b1)) u_cache_hs (
    .clk(clk), .rst(rst), .start(c_start), .ack(c_ack),
    .req(c_enable), .done_pulse(c_done), .busy(c_busy)
  );

  req_hs #(.WAIT_ACK_LOW(1'b0)) u_mem_hs (
    .clk(clk), .rst(rst), .start(m_start), .ack(mem_ack),
    .req(mem_req), .done_pulse(m_done), .busy(m_busy)
  );

  always_comb begin
    state_d    = state;
    c_rst      = 1'b0;
    c_index    = '0;
    c_word     = '0;
    c_tag_in   = '0;
    c_data_in  = '0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_done   = 1'b0;
    cpu_rdata  = '0;
    case (state)
      INIT: begin
        c_rst = c_enable;
        if (c_done) state_d = IDLE;
      end
      IDLE: begin
        if (cpu_req && !c_busy && !m_busy) state_d = LOOKUP;
      end
      LOOKUP: begin
        c_index    = addr_idx(addr_p0);
        c_word     = addr_word(addr_p0);
        c_tag_in   = addr_tag(addr_p0);
        c_data_in  = wdata_p0;
        c_comp     = 1'b1;
        c_write    = wr_p0;
        c_valid_in = 1'b1;
        if (c_done) begin
          if (c_hit && c_valid)        state_d = DONE;
          else if (c_valid && c_dirty) state_d = WB_RD;
          else                         state_d = FILL_MEM;
        end
      end
      WB_RD: begin
        c_index = addr_idx(addr_p0);
        c_word  = cnt;
        if (c_done) state_d = WB_MEM;
      end
      WB_MEM: begin
        mem_wr    = 1'b1;
        mem_addr  = make_addr(victim_tag_p1, addr_idx(addr_p0), cnt);
        mem_wdata = word_p1;
        if (m_done) state_d = (cnt == '1) ? FILL_MEM : WB_RD;
      end
      FILL_MEM: begin
        mem_addr = make_addr(addr_tag(addr_p0), addr_idx(addr_p0), cnt);
        if (m_done) state_d = FILL_WR;
      end
      FILL_WR: begin
        c_index    = addr_idx(addr_p0);
        c_word     = cnt;
        c_tag_in   = addr_tag(addr_p0);
        c_data_in  = word_p1;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        if (c_done) state_d = (cnt == '1) ? LOOKUP : FILL_MEM;
      end
      DONE: begin
        cpu_done  = 1'b1;
        cpu_rdata = wr_p0 ? '0 : rdata_p1;
        state_d   = IDLE;
      end
      default: state_d = INIT;
    endcase
    if (rst) begin
      state_d    = INIT;
      c_rst      = 1'b0;
      c_index    = '0;
      c_word     = '0;
      c_tag_in   = '0;
      c_data_in  = '0;
      c_comp     = 1'b0;
      c_write    = 1'b0;
      c_valid_in = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_done   = 1'b0;
      cpu_rdata  = '0;
    end
  end

  // The word counter wraps 3->0 on the same completion that leaves the loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if ((state == WB_MEM && m_done) || (state == FILL_WR && c_done))
        cnt <= cnt + WORD_W'(1);
      else if (state == LOOKUP && c_done)
        cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && state_d == LOOKUP) begin
      addr_p0  <= cpu_addr;
      wr_p0    <= cpu_wr;
      wdata_p0 <= cpu_wdata;
    end
    if (state == LOOKUP && c_done) begin
      rdata_p1      <= c_data_out;
      victim_tag_p1 <= c_tag_out;
    end
    if (state == WB_RD && c_done)    word_p1 <= c_data_out;
    if (state == FILL_MEM && m_done) word_p1 <= mem_rdata;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed scoreboard bench for cache_ctrl with behavioural cache array and backing memory.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int CACHE_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_wr, cpu_done;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic c_enable, c_rst, c_comp, c_write, c_valid_in;
  logic [IDX_W-1:0] c_index;
  logic [WORD_W-1:0] c_word;
  logic [TAG_W-1:0] c_tag_in, c_tag_out;
  logic [DATA_W-1:0] c_data_in, c_data_out;
  logic c_hit, c_dirty, c_valid, c_ack;
  logic mem_req, mem_wr, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .c_enable(c_enable), .c_rst(c_rst), .c_index(c_index), .c_word(c_word),
    .c_tag_in(c_tag_in), .c_data_in(c_data_in), .c_comp(c_comp), .c_write(c_write),
    .c_valid_in(c_valid_in), .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
    .c_tag_out(c_tag_out), .c_data_out(c_data_out), .c_ack(c_ack),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cache array: ack after CACHE_LAT cycles of c_enable, held until it drops.
  logic [TAG_W-1:0]  m_tag   [16];
  logic              m_valid [16];
  logic              m_dirty [16];
  logic [DATA_W-1:0] m_data  [16][4];
  logic ack_r = 1'b0;
  logic force_ack;
  int   acnt = 0;
  assign c_ack = ack_r | force_ack;

  always @(posedge clk) begin
    if (!c_enable) begin
      ack_r <= 1'b0;
      acnt  <= 0;
    end else if (!ack_r) begin
      if (acnt == CACHE_LAT - 1) begin
        ack_r <= 1'b1;
        if (c_rst) begin
          for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
          end
        end else begin
          c_tag_out  <= m_tag[c_index];
          c_valid    <= m_valid[c_index];
          c_dirty    <= m_dirty[c_index];
          c_data_out <= m_data[c_index][c_word];
          c_hit      <= c_comp && m_valid[c_index] && (m_tag[c_index] == c_tag_in);
          if (c_comp && c_write && m_valid[c_index] && (m_tag[c_index] == c_tag_in)) begin
            m_data[c_index][c_word] = c_data_in;
            m_dirty[c_index]        = 1'b1;
          end else if (!c_comp && c_write) begin
            m_data[c_index][c_word] = c_data_in;
            m_tag[c_index]          = c_tag_in;
            m_valid[c_index]        = c_valid_in;
            m_dirty[c_index]        = 1'b0;
          end
        end
      end else begin
        acnt <= acnt + 1;
      end
    end
  end

  // Backing memory: unwritten word a reads as 0xC000|a; one-cycle ack two cycles after req.
  logic [DATA_W-1:0] mem_store [int];
  int mcnt = 0;
  logic mem_ack_r = 1'b0;
  assign mem_ack = mem_ack_r;

  always @(posedge clk) begin
    if (mem_ack_r) begin
      mem_ack_r <= 1'b0;
      mcnt      <= 0;
    end else if (mem_req) begin
      if (mcnt == 1) begin
        mem_ack_r <= 1'b1;
        if (mem_wr) mem_store[int'(mem_addr)] = mem_wdata;
        else if (mem_store.exists(int'(mem_addr))) mem_rdata <= mem_store[int'(mem_addr)];
        else mem_rdata <= 16'hC000 | DATA_W'(mem_addr);
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  typedef struct {bit rd; logic [DATA_W-1:0] data;} cpu_exp_t;
  typedef struct {bit wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int init_cnt = 0, look_cnt = 0, cw_cnt = 0, cr_cnt = 0;
  int mem_cnt = 0, mem_req_cyc = 0, done_cnt = 0;
  int en_rise_cyc = 0, last_lat = 0, rise_viol = 0;
  int done_cycs[$];
  logic en_prev = 1'b0;

  // Monitor: counts handshakes and pops the scoreboards whenever the DUT presents a result.
  always @(negedge clk) begin
    if (c_enable && !en_prev) begin
      en_rise_cyc = cyc;
      if (c_ack) rise_viol++;
    end
    en_prev = c_enable;
    if (c_enable && c_ack) begin
      if (c_rst)        init_cnt++;
      else if (c_comp)  look_cnt++;
      else if (c_write) cw_cnt++;
      else              cr_cnt++;
    end
    if (mem_req) mem_req_cyc++;
    if (mem_req && mem_ack) begin
      mem_exp_t e;
      mem_cnt++;
      if (mem_q.size() == 0) begin
        chk("mem_unexpected_access", {21'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = mem_q.pop_front();
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
        chk("mem_addr", {21'd0, mem_addr}, {21'd0, e.addr});
        if (e.wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
      end
    end
    if (cpu_done) begin
      cpu_exp_t ce;
      done_cnt++;
      last_lat = cyc - en_rise_cyc;
      done_cycs.push_back(cyc);
      if (cpu_q.size() == 0) begin
        chk("cpu_unexpected_done", {16'd0, cpu_rdata}, 32'hFFFF_FFFF);
      end else begin
        ce = cpu_q.pop_front();
        if (ce.rd) chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, ce.data});
      end
    end
  end

  task automatic push_mem(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.data = d;
    mem_q.push_back(e);
  endtask

  task automatic push_cpu(input bit rd, input logic [DATA_W-1:0] d);
    cpu_exp_t e;
    e.rd = rd; e.data = d;
    cpu_q.push_back(e);
  endtask

  task automatic cpu_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_done && n < 500);
    if (!cpu_done) chk("cpu_done_timeout", 32'd0, 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int l0, w0, r0, m0, q0, d0, i0, n, k;
    rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; force_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_c_enable", {31'd0, c_enable}, 32'd0);
    chk("rst_c_rst", {31'd0, c_rst}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_cpu_done", {31'd0, cpu_done}, 32'd0);

    // Release reset with ack stuck high: INIT must wait for ack low.
    @(posedge clk); #1;
    rst = 1'b0; force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("init_waits_ack_low", {31'd0, c_enable}, 32'd0);
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    repeat (20) @(negedge clk);
    chk("init_handshakes", init_cnt, 32'd1);
    chk("init_no_mem_req", mem_req_cyc, 32'd0);
    chk("init_no_cpu_done", done_cnt, 32'd0);

    // Clean read miss of {3,5,2}.
    for (int w = 0; w < 4; w++) push_mem(1'b0, 11'h0D4 + ADDR_W'(w), '0);
    push_cpu(1'b1, 16'hC0D6);
    l0 = look_cnt; w0 = cw_cnt; r0 = cr_cnt;
    cpu_access(1'b0, 11'h0D6, '0);
    chk("miss_lookups", look_cnt - l0, 32'd2);
    chk("miss_cache_writes", cw_cnt - w0, 32'd4);
    chk("miss_cache_reads", cr_cnt - r0, 32'd0);
    chk("miss_mem_drained", mem_q.size(), 32'd0);

    // Same read again: hit.
    push_cpu(1'b1, 16'hC0D6);
    m0 = mem_req_cyc;
    cpu_access(1'b0, 11'h0D6, '0);
    chk("hit_no_mem_req", mem_req_cyc - m0, 32'd0);
    chk("hit_latency", last_lat, 32'(1 + CACHE_LAT));

    // Write hit then conflicting read: dirty write-back then fill from tag 7.
    push_cpu(1'b0, '0);
    cpu_access(1'b1, 11'h0D5, 16'hBEEF);
    push_mem(1'b1, 11'h0D4, 16'hC0D4);
    push_mem(1'b1, 11'h0D5, 16'hBEEF);
    push_mem(1'b1, 11'h0D6, 16'hC0D6);
    push_mem(1'b1, 11'h0D7, 16'hC0D7);
    for (int w = 0; w < 4; w++) push_mem(1'b0, 11'h1D4 + ADDR_W'(w), '0);
    push_cpu(1'b1, 16'hC1D4);
    r0 = cr_cnt;
    cpu_access(1'b0, 11'h1D4, '0);
    chk("wb_cache_reads", cr_cnt - r0, 32'd4);
    chk("wb_mem_drained", mem_q.size(), 32'd0);

    // Reset while the third fill read is outstanding.
    push_mem(1'b0, 11'h0D4, '0);
    push_mem(1'b0, 11'h0D5, '0);
    m0 = mem_cnt; d0 = done_cnt; i0 = init_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h0D7;
    n = 0;
    while (!(mem_req && (mem_cnt - m0) == 2) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_third_fill", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_c_enable", {31'd0, c_enable}, 32'd0);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_cpu_done", {31'd0, cpu_done}, 32'd0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_reinit", init_cnt - i0, 32'd1);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_mem_acks", mem_cnt - m0, 32'd2);

    // Re-read after abort must miss and refill the whole line.
    for (int w = 0; w < 4; w++) push_mem(1'b0, 11'h0D4 + ADDR_W'(w), '0);
    push_cpu(1'b1, 16'hC0D7);
    w0 = cw_cnt;
    cpu_access(1'b0, 11'h0D7, '0);
    chk("reread_cache_writes", cw_cnt - w0, 32'd4);
    chk("reread_mem_drained", mem_q.size(), 32'd0);

    // cpu_req held across three hits.
    repeat (3) push_cpu(1'b1, 16'hC0D7);
    q0 = done_cycs.size(); m0 = mem_cnt; l0 = look_cnt;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h0D7;
    n = 0; k = 0;
    while (k < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (cpu_done) k++;
    end
    cpu_req = 1'b0;
    chk("b2b_done_count", k, 32'd3);
    repeat (3) @(negedge clk);
    if (done_cycs.size() >= q0 + 3) begin
      chk("b2b_gap1", {31'd0, (done_cycs[q0+1] - done_cycs[q0]) >= 2}, 32'd1);
      chk("b2b_gap2", {31'd0, (done_cycs[q0+2] - done_cycs[q0+1]) >= 2}, 32'd1);
    end else begin
      chk("b2b_done_recorded", done_cycs.size() - q0, 32'd3);
    end
    chk("b2b_no_mem", mem_cnt - m0, 32'd0);
    chk("b2b_lookups", look_cnt - l0, 32'd3);

    chk("enable_rise_while_ack", rise_viol, 32'd0);
    chk("cpu_scoreboard_empty", cpu_q.size(), 32'd0);
    chk("mem_scoreboard_empty", mem_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
